// File: rtl/mul_pkg.sv
// Shared definitions for the time-multiplexed shift-add multiplier scheduler.
// Optional build macro: MUL_CT_TIME_EN (constant-time multiply, see mul_core).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    // Derived widths for the default configuration
    localparam int PROD_W = 2 * DEF_WIDTH;
    localparam int CNT_W  = $clog2(DEF_WIDTH) + 1;

    // Product width for an arbitrary operand width
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Iteration counter width: must reach w itself without wrapping
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Request/response bus between the requesters/consumer and mul_sched.
// master = requester/consumer side, slave = scheduler side.
interface mul_sched_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [2*WIDTH-1:0]    resp_data;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mul_core.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// start_i loads operands and clears the accumulator; the core then steps on
// its own until done_o and holds product_o stable until the next start.
// MUL_CT_TIME_EN defined: always WIDTH iterations (constant time).
// MUL_CT_TIME_EN undefined: finish as soon as a or the remaining b is zero.
module mul_core
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a_q};

`ifdef MUL_CT_TIME_EN
    assign done_o = (cnt_q == CW'(WIDTH));
`else
    assign done_o = (a_q == '0) || (b_q == '0);
`endif

    assign product_o = acc_q;

    // Next-state: load on start, otherwise add shifted multiplicand per set bit
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (!done_o) begin
            if (b_q[0]) begin
                acc_d = acc_q + (a_ext << cnt_q);
            end
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one mul_core among NREQ requesters.
// IDLE grants one requester, RUN waits for the core, DONE holds the
// response until the consumer takes it. Latency mode selected by
// MUL_CT_TIME_EN inside mul_core.
module mul_sched
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_sched_if.slave  bus,
    output logic        busy
);
    localparam int ID_W = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               found;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               core_done;
    logic [2*WIDTH-1:0] core_prod;

    // Round-robin winner: first valid requester after the last grant
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = found && (state_q == IDLE);

    mul_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept),
        .a_i       (sel_a),
        .b_i       (sel_b),
        .done_o    (core_done),
        .product_o (core_prod)
    );

    // State, last grant and response owner registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NREQ - 1);
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    last_d  = gnt_idx;
                    id_d    = gnt_idx;
                end
            end
            RUN:  if (core_done) state_d = DONE;
            DONE: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant only in IDLE outside reset, response only in DONE
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == IDLE) && found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        bus.resp_valid = (state_q == DONE);
        bus.resp_id    = (state_q == DONE) ? id_q : '0;
        bus.resp_data  = (state_q == DONE) ? core_prod : '0;
        busy           = (state_q != IDLE);
    end

endmodule
